// File: rtl/bitplane_reader.sv
// rtl/bitplane_reader.sv - reads an image row by row from pixel memory and presents each row as bit planes
//
// Parameters
//   IMG_W   pixels per row (width of each bit-plane row vector)
//   IMG_H   rows per image
//   PIX_W   bits per pixel (number of bit planes)
//   ADDR_W  pixel-memory address width
//
// Ports
//   clk_i          clock, all state on the rising edge
//   rst_ni         asynchronous active-low reset
//   start_i        request to read one full image (accepted only when idle)
//   base_addr_i    address of pixel (0,0), captured on accepted start
//   plane_mask_i   per-plane enable, captured on accepted start
//   mem_rd_en_o    pixel-memory read strobe
//   mem_addr_o     pixel-memory read address
//   mem_rdata_i    read data, valid one cycle after mem_rd_en_o
//   planes_o       row bit planes, plane k at [k*IMG_W +: IMG_W]
//   row_idx_o      row index of the current planes_o contents
//   out_valid_o    planes_o / row_idx_o valid
//   out_ready_i    consumer accepts the row when high with out_valid_o
//   busy_o         high whenever not idle
//   done_o         one-cycle pulse after the last row is accepted

module bitplane_reader #(
    parameter int IMG_W  = 200,
    parameter int IMG_H  = 200,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_i,
    input  logic [ADDR_W-1:0]            base_addr_i,
    input  logic [PIX_W-1:0]             plane_mask_i,
    output logic                         mem_rd_en_o,
    output logic [ADDR_W-1:0]            mem_addr_o,
    input  logic [PIX_W-1:0]             mem_rdata_i,
    output logic [PIX_W*IMG_W-1:0]       planes_o,
    output logic [((IMG_H > 1) ? $clog2(IMG_H) : 1)-1:0] row_idx_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic                         busy_o,
    output logic                         done_o
);

    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(IMG_W);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        DRAIN = 3'd2,
        OUT   = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        base_q, base_d;
    logic [PIX_W-1:0]         mask_q, mask_d;
    logic [ROW_W-1:0]         row_q, row_d;
    logic [COL_W-1:0]         col_q, col_d;
    // Running row*IMG_W offset, so the address path needs only adders.
    logic [ADDR_W-1:0]        row_base_q, row_base_d;
    logic [PIX_W*IMG_W-1:0]   planes_q, planes_d;
    // A read was issued last cycle; its data is on mem_rdata_i now.
    logic                     rd_pend_q;
    logic [COL_W-1:0]         rd_col_q;

    // Control FSM: next state and counters.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        mask_d     = mask_q;
        row_d      = row_q;
        col_d      = col_q;
        row_base_d = row_base_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    base_d     = base_addr_i;
                    mask_d     = plane_mask_i;
                    row_d      = '0;
                    col_d      = '0;
                    row_base_d = '0;
                    state_d    = READ;
                end
            end
            READ: begin
                if (col_q == COL_LAST) begin
                    col_d   = '0;
                    state_d = DRAIN;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            DRAIN: begin
                state_d = OUT;
            end
            OUT: begin
                if (out_ready_i) begin
                    if (row_q == ROW_LAST) begin
                        state_d = FIN;
                    end else begin
                        row_d      = row_q + 1'b1;
                        row_base_d = row_base_q + ROW_STRIDE;
                        col_d      = '0;
                        state_d    = READ;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Scatter the returning pixel's bits into column rd_col_q of every plane.
    always_comb begin
        planes_d = planes_q;
        if (rd_pend_q) begin
            for (int k = 0; k < PIX_W; k++) begin
                planes_d[k*IMG_W + int'(rd_col_q)] = mem_rdata_i[k] & mask_q[k];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            base_q     <= '0;
            mask_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            row_base_q <= '0;
            planes_q   <= '0;
            rd_pend_q  <= 1'b0;
            rd_col_q   <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            mask_q     <= mask_d;
            row_q      <= row_d;
            col_q      <= col_d;
            row_base_q <= row_base_d;
            planes_q   <= planes_d;
            rd_pend_q  <= (state_q == READ);
            rd_col_q   <= col_q;
        end
    end

    // Address is forced to zero outside READ so nothing stale leaks out.
    assign mem_rd_en_o = (state_q == READ);
    assign mem_addr_o  = (state_q == READ) ? (base_q + row_base_q + ADDR_W'(col_q)) : '0;
    assign planes_o    = planes_q;
    assign row_idx_o   = row_q;
    assign out_valid_o = (state_q == OUT);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == FIN);

endmodule

// File: doc/bitplane_reader.md
BITPLANE_READER -- requirements
Module: bitplane_reader

Interface
REQ-001 Parameter IMG_W, default 200, pixels per image row (width of each bit-plane row vector).
REQ-002 Parameter IMG_H, default 200, rows per image.
REQ-003 Parameter PIX_W, default 8, bits per pixel (number of bit planes).
REQ-004 Parameter ADDR_W, default 16, pixel-memory address width; IMG_W*IMG_H SHALL fit in 2^ADDR_W.
REQ-005 clk  in  1  single clock; all state rising-edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  request to read one full image; sampled only in IDLE.
REQ-008 base_addr  in  ADDR_W  address of pixel (0,0); captured on accepted start.
REQ-009 plane_mask  in  PIX_W  per-plane enable; captured on accepted start; masked planes output all zeros.
REQ-010 mem_rd_en  out  1  pixel-memory read strobe.
REQ-011 mem_addr  out  ADDR_W  pixel-memory read address.
REQ-012 mem_rdata  in  PIX_W  read data, valid exactly 1 cycle after mem_rd_en.
REQ-013 planes  out  PIX_W*IMG_W  row bit planes; plane k occupies bits [k*IMG_W+IMG_W-1 : k*IMG_W], bit c = bit k of pixel column c.
REQ-014 row_idx  out  clog2(IMG_H)  row index of the current planes contents.
REQ-015 out_valid  out  1  planes/row_idx valid.
REQ-016 out_ready  in  1  consumer accepts row when high with out_valid.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse after last row accepted.

Function
REQ-019 FSM states: IDLE, READ, DRAIN, OUT, FIN.
REQ-020 IDLE: start=1 -> capture base_addr, plane_mask; clear row and column counters; -> READ next cycle.
REQ-021 READ: mem_rd_en=1, mem_addr=base_addr+row*IMG_W+col (modulo 2^ADDR_W), col increments each cycle; after issuing col=IMG_W-1 -> DRAIN.
REQ-022 Each mem_rdata returning in the cycle after a read of column c SHALL be written to bit c of every plane k as mem_rdata[k] & plane_mask[k].
REQ-023 DRAIN: mem_rd_en=0; captures final pixel; -> OUT; a row takes IMG_W+1 cycles from READ entry to out_valid.
REQ-024 OUT: out_valid=1; planes and row_idx SHALL stay stable until out_ready=1.
REQ-025 OUT with out_ready=1: if row=IMG_H-1 -> FIN, else row+1, col=0, -> READ next cycle.
REQ-026 FIN: done=1 for one cycle, out_valid=0 -> IDLE; planes retain last row.
REQ-027 start SHALL be ignored in all states except IDLE; start held high in IDLE after FIN SHALL begin a new image the cycle after re-entering IDLE.
REQ-028 out_ready while out_valid=0 SHALL have no effect.
REQ-029 mem_rd_en SHALL be 0 outside READ; mem_addr is don't-care when mem_rd_en=0.
REQ-030 Counters SHALL not overflow: col range 0..IMG_W-1, row range 0..IMG_H-1.

Reset
REQ-031 rst_n=0 at any time, including mid-READ or mid-OUT, SHALL immediately force IDLE; planes, row_idx, mem_addr, counters all zero; mem_rd_en, out_valid, busy, done = 0.
REQ-032 After rst_n deasserts, no memory read SHALL occur until a new start is accepted; returning data from a read issued before reset SHALL be discarded.

Verification (IMG_W=4, IMG_H=2, PIX_W=8, ADDR_W=8, memory mem[a]=a)
REQ-033 base_addr=0x10, plane_mask=0xFF, start pulse, out_ready=1 -> reads 0x10..0x13, row 0 planes[3:0]=4'b1010 (plane 0), planes[7:4]=4'b1100 (plane 1); then 0x14..0x17; done pulse after row 1, busy=0 next cycle.
REQ-034 out_ready=0 for 5 cycles in OUT -> out_valid and planes stable for all 5, no mem_rd_en; row 1 reads start the cycle after out_ready=1.
REQ-035 plane_mask=0x01 -> only planes[3:0] non-zero; planes[31:4]=0 for both rows.
REQ-036 base_addr=0xFE -> addresses 0xFE,0xFF,0x00,0x01 (wrap).
REQ-037 rst_n=0 during second READ cycle -> all outputs zero within the reset cycle; after release, no mem_rd_en until start; a new start completes the image normally.
REQ-038 start pulsed during READ and OUT -> ignored; exactly 2*4 reads and one done pulse.
